// File: rtl/mpt_pkg.sv
// Shared types for the MPT walker request scheduler: transaction payload, CSR image,
// scheduler FSM states and slot-table entries.
package mpt_pkg;

    localparam int unsigned XLEN                 = 64;
    localparam int unsigned MPTW_SCHED_MAX_REQ   = 8;
    localparam int unsigned MPTW_SCHED_MAX_SLOTS = 16;
    localparam int unsigned MPTW_SCHED_REQ_W     = $clog2(MPTW_SCHED_MAX_REQ);
    localparam int unsigned MPTW_SCHED_ID_W      = $clog2(MPTW_SCHED_MAX_SLOTS);

    typedef enum logic [1:0] {
        ACCESS_NONE,
        ACCESS_READ,
        ACCESS_WRITE,
        ACCESS_EXECUTE
    } mpt_access_e;

    typedef enum logic [2:0] {
        FMT_NO_ERROR,
        FMT_RESERVED_BITS,
        FMT_LEAF_MISALIGNED,
        FMT_INVALID_MODE
    } page_format_fault_e;

    typedef struct packed {
        logic [3:0]  mode;
        logic [15:0] sdid;
        logic [43:0] ppn;
    } mmpt_reg_t;

    typedef struct packed {
        logic                       valid;
        logic [MPTW_SCHED_ID_W-1:0] id;
        logic                       speculative;
        logic                       plb_hit;
        logic                       completed;
        logic                       walking;
        mmpt_reg_t                  mmpt;
        logic [XLEN-1:0]            spa;
        mpt_access_e                access_type;
        logic [63:0]                mpte;
        logic [XLEN-1:0]            mpte_ptr;
        logic                       access_fault;
        page_format_fault_e         format_error;
    } mptw_transaction_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } sched_state_e;

    typedef struct packed {
        logic                        valid;
        logic [MPTW_SCHED_REQ_W-1:0] owner;
    } sched_slot_t;

endpackage

// File: rtl/mptw_rr_arbiter.sv
// Round-robin picker: one-hot grant to the first requester at or after ptr_i.
module mptw_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!found && req_i[j] && (((32'(ptr_i) + i) % NUM_REQ) == j)) begin
                    gnt_o[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mptw_request_scheduler.sv
// Issues requester transactions into the MPT walking pipeline and routes completions back.
// Optional performance counters: define MPTW_SCHED_PERF_CNT_EN.
module mptw_request_scheduler
    import mpt_pkg::*;
#(
    parameter int unsigned NUM_REQ             = 2,
    parameter int unsigned MAX_OUTSTANDING     = 4,
    parameter int unsigned PIPELINE_DATA_WIDTH = $bits(mptw_transaction_t)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [NUM_REQ-1:0][XLEN-1:0]       req_spa_i,
    input  mpt_access_e [NUM_REQ-1:0]          req_access_i,
    input  mmpt_reg_t                          mmpt_i,
    input  logic                               mmpt_update_i,
    output logic                               walk_valid_o,
    input  logic                               walk_ready_i,
    output logic [PIPELINE_DATA_WIDTH-1:0]     walk_data_o,
    input  logic                               cmpl_valid_i,
    output logic                               cmpl_ready_o,
    input  logic [PIPELINE_DATA_WIDTH-1:0]     cmpl_data_i,
    output logic [NUM_REQ-1:0]                 rsp_valid_o,
    output logic                               rsp_access_fault_o,
    output page_format_fault_e                 rsp_format_error_o,
    output logic                               busy_o,
    output logic                               spurious_cmpl_o
`ifdef MPTW_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]                        perf_issued_o,
    output logic [31:0]                        perf_faults_o,
    output logic [31:0]                        perf_stall_cycles_o
`endif
);

    localparam int unsigned TXN_W  = $bits(mptw_transaction_t);
    localparam int unsigned SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned REQ_W  = MPTW_SCHED_REQ_W;
    localparam int unsigned ID_W   = MPTW_SCHED_ID_W;

    sched_state_e       state_q, state_d;
    logic [REQ_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [REQ_W-1:0]   grant_q, grant_d;
    logic               walk_valid_q, walk_valid_d;
    mptw_transaction_t  walk_txn_q, walk_txn_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               rsp_fault_q, rsp_fault_d;
    page_format_fault_e rsp_fmt_q, rsp_fmt_d;
    logic               spurious_q, spurious_d;
    mmpt_reg_t          mmpt_active_q, mmpt_active_d;
    mmpt_reg_t          mmpt_latched_q, mmpt_latched_d;
    logic               update_pend_q, update_pend_d;
    sched_slot_t        slot_q [MAX_OUTSTANDING];
    sched_slot_t        slot_d [MAX_OUTSTANDING];

    logic [NUM_REQ-1:0] arb_gnt;
    logic [REQ_W-1:0]   gnt_idx;
    logic [XLEN-1:0]    sel_spa;
    mpt_access_e        sel_access;
    logic               any_slot;
    logic               free_found;
    logic [ID_W-1:0]    free_id;
    logic [TXN_W-1:0]   walk_bits;
    logic [TXN_W-1:0]   cmpl_bits;
    mptw_transaction_t  cmpl_txn;
    logic [SLOT_W-1:0]  cmpl_slot;
    logic [SLOT_W-1:0]  iss_slot;
    logic               cmpl_hit;
    logic               handshake;
    logic               unused_cmpl;

    mptw_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (REQ_W)
    ) u_rr_arbiter (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt)
    );

    assign cmpl_bits   = TXN_W'(cmpl_data_i);
    assign cmpl_txn    = cmpl_bits;
    assign unused_cmpl = ^cmpl_bits;
    assign cmpl_slot   = cmpl_txn.id[SLOT_W-1:0];
    assign iss_slot    = walk_txn_q.id[SLOT_W-1:0];
    assign handshake   = walk_valid_q & walk_ready_i;
    assign cmpl_hit    = cmpl_valid_i && (32'(cmpl_txn.id) < MAX_OUTSTANDING) && slot_q[cmpl_slot].valid;

    // Slot occupancy, lowest free id and the granted requester's payload.
    always_comb begin
        any_slot   = 1'b0;
        free_found = 1'b0;
        free_id    = '0;
        for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            if (slot_q[i].valid) begin
                any_slot = 1'b1;
            end else if (!free_found) begin
                free_found = 1'b1;
                free_id    = ID_W'(i);
            end
        end
        gnt_idx    = '0;
        sel_spa    = '0;
        sel_access = ACCESS_NONE;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (arb_gnt[j]) begin
                gnt_idx    = REQ_W'(j);
                sel_spa    = req_spa_i[j];
                sel_access = req_access_i[j];
            end
        end
    end

    // Scheduler FSM, slot table and completion routing.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_d        = grant_q;
        walk_valid_d   = walk_valid_q;
        walk_txn_d     = walk_txn_q;
        rsp_valid_d    = '0;
        rsp_fault_d    = 1'b0;
        rsp_fmt_d      = FMT_NO_ERROR;
        spurious_d     = spurious_q;
        mmpt_active_d  = mmpt_active_q;
        mmpt_latched_d = mmpt_latched_q;
        update_pend_d  = update_pend_q;
        slot_d         = slot_q;

        if (mmpt_update_i) begin
            mmpt_latched_d = mmpt_i;
        end

        unique case (state_q)
            IDLE: begin
                if (mmpt_update_i) begin
                    state_d = DRAIN;
                end else if ((|req_valid_i) && free_found) begin
                    state_d                = ISSUE;
                    grant_d                = gnt_idx;
                    walk_valid_d           = 1'b1;
                    walk_txn_d             = '0;
                    walk_txn_d.valid       = 1'b1;
                    walk_txn_d.id          = free_id;
                    walk_txn_d.walking     = 1'b1;
                    walk_txn_d.mmpt        = mmpt_active_q;
                    walk_txn_d.spa         = sel_spa;
                    walk_txn_d.access_type = sel_access;
                end
            end
            ISSUE: begin
                if (mmpt_update_i) begin
                    update_pend_d = 1'b1;
                end
                if (handshake) begin
                    walk_valid_d           = 1'b0;
                    rr_ptr_d               = (grant_q == REQ_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    slot_d[iss_slot].valid = 1'b1;
                    slot_d[iss_slot].owner = grant_q;
                    state_d                = (update_pend_q || mmpt_update_i) ? DRAIN : IDLE;
                    update_pend_d          = 1'b0;
                end
            end
            DRAIN: begin
                if (!any_slot && !mmpt_update_i) begin
                    mmpt_active_d = mmpt_latched_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cmpl_valid_i) begin
            if (cmpl_hit) begin
                slot_d[cmpl_slot].valid = 1'b0;
                for (int unsigned j = 0; j < NUM_REQ; j++) begin
                    if (slot_q[cmpl_slot].owner == REQ_W'(j)) begin
                        rsp_valid_d[j] = 1'b1;
                    end
                end
                rsp_fault_d = cmpl_txn.access_fault;
                rsp_fmt_d   = cmpl_txn.format_error;
            end else begin
                spurious_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            walk_valid_q   <= 1'b0;
            walk_txn_q     <= '0;
            rsp_valid_q    <= '0;
            rsp_fault_q    <= 1'b0;
            rsp_fmt_q      <= FMT_NO_ERROR;
            spurious_q     <= 1'b0;
            mmpt_active_q  <= '0;
            mmpt_latched_q <= '0;
            update_pend_q  <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_q        <= grant_d;
            walk_valid_q   <= walk_valid_d;
            walk_txn_q     <= walk_txn_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_fault_q    <= rsp_fault_d;
            rsp_fmt_q      <= rsp_fmt_d;
            spurious_q     <= spurious_d;
            mmpt_active_q  <= mmpt_active_d;
            mmpt_latched_q <= mmpt_latched_d;
            update_pend_q  <= update_pend_d;
            slot_q         <= slot_d;
        end
    end

    // Ready is the handshake itself, so it cannot be a registered copy.
    always_comb begin
        req_ready_o = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (handshake && (grant_q == REQ_W'(j))) begin
                req_ready_o[j] = 1'b1;
            end
        end
    end

    assign walk_bits          = walk_txn_q;
    assign walk_data_o        = PIPELINE_DATA_WIDTH'(walk_bits);
    assign walk_valid_o       = walk_valid_q;
    assign cmpl_ready_o       = 1'b1;
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_access_fault_o = rsp_fault_q;
    assign rsp_format_error_o = rsp_fmt_q;
    assign spurious_cmpl_o    = spurious_q;
    assign busy_o             = (state_q != IDLE) || any_slot || (|req_valid_i);

`ifdef MPTW_SCHED_PERF_CNT_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_faults_q, perf_faults_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issued_d = perf_issued_q + 32'(handshake);
        perf_faults_d = perf_faults_q +
                        32'(cmpl_hit && (cmpl_txn.access_fault || (cmpl_txn.format_error != FMT_NO_ERROR)));
        perf_stall_d  = perf_stall_q + 32'(walk_valid_q && !walk_ready_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_issued_q <= '0;
            perf_faults_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_faults_q <= perf_faults_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued_o       = perf_issued_q;
    assign perf_faults_o       = perf_faults_q;
    assign perf_stall_cycles_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_mptw_request_scheduler.sv
// Directed self-checking bench for mptw_request_scheduler (default parameters).
module tb_mptw_request_scheduler;
    import mpt_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned TW   = $bits(mptw_transaction_t);

    logic                          clk_i = 1'b0;
    logic                          rst_ni = 1'b0;
    logic [NREQ-1:0]               req_valid_i;
    logic [NREQ-1:0]               req_ready_o;
    logic [NREQ-1:0][XLEN-1:0]     req_spa_i;
    mpt_access_e [NREQ-1:0]        req_access_i;
    mmpt_reg_t                     mmpt_i;
    logic                          mmpt_update_i;
    logic                          walk_valid_o;
    logic                          walk_ready_i;
    logic [TW-1:0]                 walk_data_o;
    logic                          cmpl_valid_i;
    logic                          cmpl_ready_o;
    logic [TW-1:0]                 cmpl_data_i;
    logic [NREQ-1:0]               rsp_valid_o;
    logic                          rsp_access_fault_o;
    page_format_fault_e            rsp_format_error_o;
    logic                          busy_o;
    logic                          spurious_cmpl_o;
`ifdef MPTW_SCHED_PERF_CNT_EN
    logic [31:0]                   perf_issued_o;
    logic [31:0]                   perf_faults_o;
    logic [31:0]                   perf_stall_cycles_o;
`endif

    mptw_transaction_t wtxn;
    mptw_transaction_t ctxn;
    logic [TW-1:0]     bp_data;
    int                n_checks = 0;
    int                n_errors = 0;

    assign wtxn        = walk_data_o;
    assign cmpl_data_i = ctxn;

    always #5 clk_i = ~clk_i;

    mptw_request_scheduler dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_spa_i          (req_spa_i),
        .req_access_i       (req_access_i),
        .mmpt_i             (mmpt_i),
        .mmpt_update_i      (mmpt_update_i),
        .walk_valid_o       (walk_valid_o),
        .walk_ready_i       (walk_ready_i),
        .walk_data_o        (walk_data_o),
        .cmpl_valid_i       (cmpl_valid_i),
        .cmpl_ready_o       (cmpl_ready_o),
        .cmpl_data_i        (cmpl_data_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_access_fault_o (rsp_access_fault_o),
        .rsp_format_error_o (rsp_format_error_o),
        .busy_o             (busy_o),
        .spurious_cmpl_o    (spurious_cmpl_o)
`ifdef MPTW_SCHED_PERF_CNT_EN
        ,
        .perf_issued_o       (perf_issued_o),
        .perf_faults_o       (perf_faults_o),
        .perf_stall_cycles_o (perf_stall_cycles_o)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_walk(input string tag);
        int n = 0;
        while (!walk_valid_o && n < 20) begin
            tick();
            n++;
        end
        if (!walk_valid_o) check({tag, "_timeout"}, 64'(walk_valid_o), 64'h1);
    endtask

    task automatic complete(input logic [3:0] id, input logic af, input page_format_fault_e fe);
        ctxn              = '0;
        ctxn.valid        = 1'b1;
        ctxn.id           = id;
        ctxn.completed    = 1'b1;
        ctxn.access_fault = af;
        ctxn.format_error = fe;
        cmpl_valid_i      = 1'b1;
        tick();
        cmpl_valid_i      = 1'b0;
        ctxn              = '0;
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        req_valid_i = '0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid_i     = '0;
        req_spa_i[0]    = 64'h8000_1000;
        req_spa_i[1]    = 64'h9000_2000;
        req_access_i[0] = ACCESS_READ;
        req_access_i[1] = ACCESS_WRITE;
        mmpt_i          = '0;
        mmpt_update_i   = 1'b0;
        walk_ready_i    = 1'b0;
        cmpl_valid_i    = 1'b0;
        ctxn            = '0;

        // Reset state
        tick();
        tick();
        check("rst_walk_valid", 64'(walk_valid_o), 64'h0);
        check("rst_req_ready", 64'(req_ready_o), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
        check("rst_spurious", 64'(spurious_cmpl_o), 64'h0);
        check("rst_busy", 64'(busy_o), 64'h0);
        check("cmpl_ready", 64'(cmpl_ready_o), 64'h1);
        rst_ni = 1'b1;
        tick();

        // Single request
        walk_ready_i = 1'b1;
        req_valid_i  = 2'b01;
        check("single_pre_valid", 64'(walk_valid_o), 64'h0);
        tick();
        check("single_walk_valid", 64'(walk_valid_o), 64'h1);
        check("single_id", 64'(wtxn.id), 64'h0);
        check("single_spa", wtxn.spa, 64'h8000_1000);
        check("single_access", 64'(wtxn.access_type), 64'(ACCESS_READ));
        check("single_flags", 64'({wtxn.valid, wtxn.speculative, wtxn.plb_hit, wtxn.completed, wtxn.walking}),
              64'h11);
        check("single_mmpt", 64'(wtxn.mmpt), 64'h0);
        check("single_mpte", wtxn.mpte, 64'h0);
        #1;
        check("single_ready", 64'(req_ready_o), 64'h1);
        tick();
        check("single_after_hs", 64'(walk_valid_o), 64'h0);
        check("single_busy", 64'(busy_o), 64'h1);
        req_valid_i = '0;
        complete(4'd0, 1'b0, FMT_NO_ERROR);
        check("single_rsp", 64'(rsp_valid_o), 64'h1);
        check("single_rsp_fault", 64'(rsp_access_fault_o), 64'h0);
        tick();
        check("single_rsp_pulse", 64'(rsp_valid_o), 64'h0);
        check("single_idle_busy", 64'(busy_o), 64'h0);

        // Fairness: alternating grants, ids 0..3, then full
        do_reset();
        req_valid_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_walk("fair");
            check("fair_id", 64'(wtxn.id), 64'(k));
            check("fair_spa", wtxn.spa, (k % 2 == 0) ? 64'h8000_1000 : 64'h9000_2000);
            #1;
            check("fair_grant", 64'(req_ready_o), (k % 2 == 0) ? 64'h1 : 64'h2);
            tick();
        end
        repeat (4) tick();
        check("full_stall", 64'(walk_valid_o), 64'h0);
        check("full_busy", 64'(busy_o), 64'h1);
        complete(4'd0, 1'b1, FMT_LEAF_MISALIGNED);
        check("fault_rsp", 64'(rsp_valid_o), 64'h1);
        check("fault_af", 64'(rsp_access_fault_o), 64'h1);
        check("fault_fmt", 64'(rsp_format_error_o), 64'(FMT_LEAF_MISALIGNED));
        check("freed_not_reused", 64'(walk_valid_o), 64'h0);
        tick();
        check("fifth_valid", 64'(walk_valid_o), 64'h1);
        check("fifth_id", 64'(wtxn.id), 64'h0);
        #1;
        check("fifth_grant", 64'(req_ready_o), 64'h1);

        // Backpressure
        walk_ready_i = 1'b0;
        bp_data      = walk_data_o;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", 64'(walk_valid_o), 64'h1);
            check("bp_stable", 64'(walk_data_o == bp_data), 64'h1);
            check("bp_ready", 64'(req_ready_o), 64'h0);
        end
`ifdef MPTW_SCHED_PERF_CNT_EN
        check("perf_stall", 64'(perf_stall_cycles_o), 64'd5);
        check("perf_issued", 64'(perf_issued_o), 64'd4);
        check("perf_faults", 64'(perf_faults_o), 64'd1);
`endif
        walk_ready_i = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_ready_o), 64'h1);
        tick();
        req_valid_i = '0;

        // Same-cycle completion and issue
        complete(4'd3, 1'b0, FMT_NO_ERROR);
        check("sc_rsp3", 64'(rsp_valid_o), 64'h2);
        req_valid_i = 2'b01;
        tick();
        check("sc_valid", 64'(walk_valid_o), 64'h1);
        check("sc_id3", 64'(wtxn.id), 64'h3);
        complete(4'd2, 1'b0, FMT_NO_ERROR);
        check("sc_rsp2", 64'(rsp_valid_o), 64'h1);
        check("sc_hs_done", 64'(walk_valid_o), 64'h0);
        tick();
        check("sc_reuse_valid", 64'(walk_valid_o), 64'h1);
        check("sc_reuse_id", 64'(wtxn.id), 64'h2);
        tick();
        req_valid_i = '0;

        // Drain on CSR update
        complete(4'd3, 1'b0, FMT_NO_ERROR);
        check("dr_rsp3", 64'(rsp_valid_o), 64'h1);
        mmpt_i.ppn    = 44'h123;
        mmpt_update_i = 1'b1;
        req_valid_i   = 2'b01;
        tick();
        mmpt_update_i = 1'b0;
        mmpt_i.ppn    = 44'h777;
        check("dr_no_issue0", 64'(walk_valid_o), 64'h0);
        repeat (3) tick();
        check("dr_no_issue1", 64'(walk_valid_o), 64'h0);
        complete(4'd0, 1'b0, FMT_NO_ERROR);
        check("dr_rsp0", 64'(rsp_valid_o), 64'h1);
        complete(4'd1, 1'b0, FMT_NO_ERROR);
        check("dr_rsp1", 64'(rsp_valid_o), 64'h2);
        check("dr_no_issue2", 64'(walk_valid_o), 64'h0);
        complete(4'd2, 1'b0, FMT_NO_ERROR);
        check("dr_rsp2", 64'(rsp_valid_o), 64'h1);
        check("dr_no_issue3", 64'(walk_valid_o), 64'h0);
        wait_walk("drain");
        check("dr_new_id", 64'(wtxn.id), 64'h0);
        check("dr_new_ppn", 64'(wtxn.mmpt.ppn), 64'h123);
        tick();
        req_valid_i = '0;

        // Unknown completion id
        complete(4'd5, 1'b0, FMT_NO_ERROR);
        check("spur_no_rsp", 64'(rsp_valid_o), 64'h0);
        check("spur_flag", 64'(spurious_cmpl_o), 64'h1);

        // Reset mid-walk
        req_valid_i  = 2'b10;
        walk_ready_i = 1'b0;
        wait_walk("midwalk");
        rst_ni      = 1'b0;
        req_valid_i = '0;
        #1;
        check("mrst_walk_valid", 64'(walk_valid_o), 64'h0);
        check("mrst_walk_data", 64'(walk_data_o == '0), 64'h1);
        check("mrst_req_ready", 64'(req_ready_o), 64'h0);
        check("mrst_rsp", 64'(rsp_valid_o), 64'h0);
        check("mrst_spurious", 64'(spurious_cmpl_o), 64'h0);
        check("mrst_busy", 64'(busy_o), 64'h0);
`ifdef MPTW_SCHED_PERF_CNT_EN
        check("mrst_perf_stall", 64'(perf_stall_cycles_o), 64'd0);
`endif
        tick();
        rst_ni = 1'b1;
        tick();
        complete(4'd0, 1'b0, FMT_NO_ERROR);
        check("late_no_rsp", 64'(rsp_valid_o), 64'h0);
        check("late_spurious", 64'(spurious_cmpl_o), 64'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
